// File: rtl/sc_cell_bist.sv
// BIST sequencer for one library cell: walks N_PAT stimulus patterns, checks RESP against a golden cell model.
// Optional first-failure logging of FAIL_IDX is enabled with the CELL_BIST_FAILLOG_EN macro.
module sc_cell_bist #(
  parameter int N_PAT = 16,
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VPW,
  input  logic             VNW,
  input  logic             VDD,
  input  logic             VSS,
  input  logic             START,
  input  logic [4:0]       SEL,
  output logic [3:0]       STIM,
  input  logic             RESP,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERRCNT,
  output logic [7:0]       FAIL_IDX
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;

  localparam logic [7:0]       LAST_IDX = 8'(N_PAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [4:0]       SEL_DFF  = 5'd24;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [3:0]       stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             mismatch_s;
  logic             unused_pins;

  assign unused_pins = ^{VPW, VNW, VDD, VSS};

  // The flop's D is STIM[0], so its Q at a compare is bit 0 of the previous pattern, i.e. ~idx[0].
  function automatic logic golden(input logic [4:0] sel, input logic [3:0] s, input logic [7:0] idx);
    logic a, b, c, d, g;
    a = s[0];
    b = s[1];
    c = s[2];
    d = s[3];
    case (sel)
      5'd0:    g = ~a;
      5'd1:    g = ~(a & b);
      5'd2:    g = ~(~a & b);
      5'd3:    g = ~(a & b & c);
      5'd4:    g = ~(a & b & c & d);
      5'd5:    g = ~(a | b);
      5'd6:    g = ~(a | ~b);
      5'd7:    g = ~(a | b | c);
      5'd8:    g = a & b;
      5'd9:    g = a | b;
      5'd10:   g = ~(a ^ b);
      5'd11:   g = (a & b) | (a & c) | (b & c);
      5'd12:   g = ~((a & b) | c);
      5'd13:   g = ~((a & b) | ~c);
      5'd14:   g = (a & b) | c;
      5'd15:   g = (a & b) | ~c;
      5'd16:   g = ~((a & b) | (c & d));
      5'd17:   g = (a & b) | (c & d);
      5'd18:   g = ~((a & b & c) | d);
      5'd19:   g = (a & b & c) | d;
      5'd20:   g = c ? b : a;
      5'd21:   g = a;
      5'd22:   g = 1'b1;
      5'd23:   g = 1'b0;
      5'd24:   g = ~idx[0];
      default: g = 1'b0;
    endcase
    return g;
  endfunction

  always_comb begin
    if (SEL > SEL_DFF) begin
      mismatch_s = 1'b1;
    end else if (SEL == SEL_DFF && idx_q == 8'd0) begin
      mismatch_s = 1'b0;
    end else begin
      mismatch_s = (RESP != golden(SEL, stim_q, idx_q));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          stim_d  = 4'd0;
          idx_d   = 8'd0;
          err_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SAMPLE;
        end else begin
          state_d = state_q;
        end
      end
      SAMPLE: begin
        if (mismatch_s && err_q != ERR_MAX) begin
          err_d = err_q + ERR_W'(1);
        end else begin
          err_d = err_q;
        end
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        stim_d  = idx_q[3:0];
        state_d = SAMPLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= 8'd0;
      stim_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

`ifdef CELL_BIST_FAILLOG_EN
  logic [7:0] fail_idx_q, fail_idx_d;

  // A zero error count during SAMPLE means no earlier mismatch in this run (the counter never wraps).
  always_comb begin
    fail_idx_d = fail_idx_q;
    if ((state_q == IDLE || state_q == FIN) && START) begin
      fail_idx_d = 8'd0;
    end else if (state_q == SAMPLE && mismatch_s && err_q == '0) begin
      fail_idx_d = idx_q;
    end else begin
      fail_idx_d = fail_idx_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fail_idx_q <= 8'd0;
    end else begin
      fail_idx_q <= fail_idx_d;
    end
  end

  assign FAIL_IDX = fail_idx_q;
`else
  assign FAIL_IDX = 8'd0;
`endif

  assign STIM   = stim_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign PASS   = pass_q;
  assign ERRCNT = err_q;

endmodule

// File: tb/tb_sc_cell_bist.sv
// Directed bench for sc_cell_bist: one 8-bit-counter instance and one saturating 2-bit-counter instance in lockstep.
module tb_sc_cell_bist;

  localparam int NP = 16;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] sel;
  logic       resp;
  logic [3:0] stim0, stim1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] err0;
  logic [1:0] err1;
  logic [7:0] fidx0, fidx1;
  logic       dff_q;
  int         mode;
  int         n_vec;
  int         n_err;

  sc_cell_bist #(.N_PAT(NP), .ERR_W(8)) dut0 (
    .CLK(clk), .RST(rst), .VPW(1'b1), .VNW(1'b0), .VDD(1'b1), .VSS(1'b0),
    .START(start), .SEL(sel), .STIM(stim0), .RESP(resp), .BUSY(busy0),
    .DONE(done0), .PASS(pass0), .ERRCNT(err0), .FAIL_IDX(fidx0)
  );

  sc_cell_bist #(.N_PAT(NP), .ERR_W(2)) dut1 (
    .CLK(clk), .RST(rst), .VPW(1'b1), .VNW(1'b0), .VDD(1'b1), .VSS(1'b0),
    .START(start), .SEL(sel), .STIM(stim1), .RESP(resp), .BUSY(busy1),
    .DONE(done1), .PASS(pass1), .ERRCNT(err1), .FAIL_IDX(fidx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flop CUT: D = STIM[0], clocked by the same clock as the sequencer.
  always_ff @(posedge clk) dff_q <= stim0[0];

  // Modes: 0 correct cell model, 1 stuck-0, 2 stuck-1, 3 RESP wired to STIM[0], 4 flop model.
  always_comb begin
    resp = 1'b0;
    case (mode)
      0: begin
        if (sel == 5'd20) resp = stim0[2] ? stim0[1] : stim0[0];
        else              resp = ~(stim0[0] & stim0[1]);
      end
      1: resp = 1'b0;
      2: resp = 1'b1;
      3: resp = stim0[0];
      4: resp = dff_q;
      default: resp = 1'b0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input logic [4:0] s, input int m, input int exp_err, input int exp_fi, input bit mid_start);
    int done_at;
    int busy_n;
    int fi;
    sel   = s;
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_done_low", 32'(done0), 32'd0);
    check_eq("start_err_clr", 32'(err0), 32'd0);
    check_eq("start_stim0", 32'(stim0), 32'd0);
    done_at = -1;
    busy_n  = 0;
    for (int i = 0; i < 100 && done_at < 0; i++) begin
      if (i > 0) @(negedge clk);
      start = (mid_start && i == 5);
      if (busy0) busy_n++;
      if (done0) done_at = i;
    end
    start = 1'b0;
    fi = exp_fi;
`ifndef CELL_BIST_FAILLOG_EN
    fi = 0;
`endif
    check_eq($sformatf("done_edge_sel%0d", s), 32'(done_at), 32'(2 * NP - 1));
    check_eq($sformatf("busy_cycles_sel%0d", s), 32'(busy_n), 32'(2 * NP - 1));
    check_eq($sformatf("errcnt_sel%0d", s), 32'(err0), 32'(exp_err));
    check_eq($sformatf("pass_sel%0d", s), 32'(pass0), 32'(exp_err == 0));
    check_eq($sformatf("fail_idx_sel%0d", s), 32'(fidx0), 32'(fi));
    check_eq($sformatf("errcnt_w2_sel%0d", s), 32'(err1), 32'((exp_err > 3) ? 3 : exp_err));
    check_eq($sformatf("pass_w2_sel%0d", s), 32'(pass1), 32'(exp_err == 0));
    check_eq($sformatf("stim_hold_sel%0d", s), 32'(stim0), 32'd15);
    check_eq($sformatf("busy_off_sel%0d", s), 32'(busy0), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    sel   = 5'd1;
    mode  = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_stim", 32'(stim0), 32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_done", 32'(done0), 32'd0);
    check_eq("rst_pass", 32'(pass0), 32'd0);
    check_eq("rst_err", 32'(err0), 32'd0);
    check_eq("rst_fidx", 32'(fidx0), 32'd0);

    run(5'd1,  0, 0,  0,  1'b1);
    run(5'd1,  1, 12, 0,  1'b0);
    run(5'd24, 4, 0,  0,  1'b0);
    run(5'd24, 3, 15, 1,  1'b0);
    run(5'd22, 1, 16, 0,  1'b0);
    run(5'd27, 1, 16, 0,  1'b0);
    run(5'd10, 1, 8,  0,  1'b0);
    run(5'd4,  2, 1,  15, 1'b0);
    run(5'd20, 0, 0,  0,  1'b0);
    run(5'd13, 1, 6,  4,  1'b0);
    run(5'd6,  1, 4,  2,  1'b0);
    run(5'd18, 2, 9,  7,  1'b0);
    run(5'd2,  2, 4,  2,  1'b0);
    run(5'd0,  1, 8,  0,  1'b0);

    // Reset during pattern 5 of a nand2 stuck-0 run.
    sel   = 5'd1;
    mode  = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid_stim5", 32'(stim0), 32'd5);
    check_eq("mid_err4", 32'(err0), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_stim", 32'(stim0), 32'd0);
    check_eq("mid_rst_busy", 32'(busy0), 32'd0);
    check_eq("mid_rst_done", 32'(done0), 32'd0);
    check_eq("mid_rst_err", 32'(err0), 32'd0);
    @(negedge clk);
    run(5'd1, 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
